// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared constants and types for instr_stream_encoder.
//  - ENC_CLASS_*    : micro-op class codes (3 bits, all eight codes used)
//  - ALUCTRL_*      : control-unit ALU codes, same values as alu_control_def.v
//  - OPC_* / F3_* / F7_* : RV32I/M opcode and function-field constants
//  - fifo_entry_t   : buffered encoded word plus end-of-program marker
//  - enc_state_e    : write FSM states
package instr_enc_pkg;

  localparam int INSTR_W = 32;

  // micro-op classes
  localparam logic [2:0] ENC_CLASS_R      = 3'd0;
  localparam logic [2:0] ENC_CLASS_I_CALC = 3'd1;
  localparam logic [2:0] ENC_CLASS_LOAD   = 3'd2;
  localparam logic [2:0] ENC_CLASS_STORE  = 3'd3;
  localparam logic [2:0] ENC_CLASS_BRANCH = 3'd4;
  localparam logic [2:0] ENC_CLASS_JAL    = 3'd5;
  localparam logic [2:0] ENC_CLASS_JALR   = 3'd6;
  localparam logic [2:0] ENC_CLASS_AUIPC  = 3'd7;

  // ALU control codes; MUL..REMU must stay consecutive (f3 = code - MUL)
  localparam logic [4:0] ALUCTRL_ADD    = 5'd0;
  localparam logic [4:0] ALUCTRL_SUB    = 5'd1;
  localparam logic [4:0] ALUCTRL_SLL    = 5'd2;
  localparam logic [4:0] ALUCTRL_SLT    = 5'd3;
  localparam logic [4:0] ALUCTRL_SLTU   = 5'd4;
  localparam logic [4:0] ALUCTRL_XOR    = 5'd5;
  localparam logic [4:0] ALUCTRL_SRL    = 5'd6;
  localparam logic [4:0] ALUCTRL_SRA    = 5'd7;
  localparam logic [4:0] ALUCTRL_OR     = 5'd8;
  localparam logic [4:0] ALUCTRL_AND    = 5'd9;
  localparam logic [4:0] ALUCTRL_MUL    = 5'd10;
  localparam logic [4:0] ALUCTRL_MULH   = 5'd11;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'd12;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'd13;
  localparam logic [4:0] ALUCTRL_DIV    = 5'd14;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'd15;
  localparam logic [4:0] ALUCTRL_REM    = 5'd16;
  localparam logic [4:0] ALUCTRL_REMU   = 5'd17;
  localparam logic [4:0] ALUCTRL_BEQ    = 5'd18;
  localparam logic [4:0] ALUCTRL_BNE    = 5'd19;
  localparam logic [4:0] ALUCTRL_BLT    = 5'd20;
  localparam logic [4:0] ALUCTRL_BGE    = 5'd21;
  localparam logic [4:0] ALUCTRL_BLTU   = 5'd22;
  localparam logic [4:0] ALUCTRL_BGEU   = 5'd23;
  localparam logic [4:0] ALUCTRL_JAL    = 5'd24;
  localparam logic [4:0] ALUCTRL_JALR   = 5'd25;
  localparam logic [4:0] ALUCTRL_AUIPC  = 5'd26;
  localparam logic [4:0] ALUCTRL_NOP    = 5'd31;

  // opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 / funct7
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef struct packed {
    logic              last;
    logic [INSTR_W-1:0] word;
  } fifo_entry_t;

  typedef struct packed {
    logic       ok;
    logic       alt;   // funct7 = 0x20 (SUB/SRA)
    logic [2:0] f3;
  } op_dec_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_STALL, ST_DONE} enc_state_e;

  // base-ISA ALU ops shared by OP and OP-IMM
  function automatic op_dec_t alu_decode(input logic [4:0] c);
    op_dec_t d;
    d = '{ok: 1'b1, alt: 1'b0, f3: F3_ADD};
    case (c)
      ALUCTRL_ADD:  d.f3 = F3_ADD;
      ALUCTRL_SUB:  begin d.f3 = F3_ADD; d.alt = 1'b1; end
      ALUCTRL_SLL:  d.f3 = F3_SLL;
      ALUCTRL_SLT:  d.f3 = F3_SLT;
      ALUCTRL_SLTU: d.f3 = F3_SLTU;
      ALUCTRL_XOR:  d.f3 = F3_XOR;
      ALUCTRL_SRL:  d.f3 = F3_SR;
      ALUCTRL_SRA:  begin d.f3 = F3_SR; d.alt = 1'b1; end
      ALUCTRL_OR:   d.f3 = F3_OR;
      ALUCTRL_AND:  d.f3 = F3_AND;
      default:      d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic op_dec_t branch_decode(input logic [4:0] c);
    op_dec_t d;
    d = '{ok: 1'b1, alt: 1'b0, f3: F3_BEQ};
    case (c)
      ALUCTRL_BEQ:  d.f3 = F3_BEQ;
      ALUCTRL_BNE:  d.f3 = F3_BNE;
      ALUCTRL_BLT:  d.f3 = F3_BLT;
      ALUCTRL_BGE:  d.f3 = F3_BGE;
      ALUCTRL_BLTU: d.f3 = F3_BLTU;
      ALUCTRL_BGEU: d.f3 = F3_BGEU;
      default:      d.ok = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_muldiv(input logic [4:0] c);
    return (c >= ALUCTRL_MUL) && (c <= ALUCTRL_REMU);
  endfunction

  function automatic logic [2:0] muldiv_f3(input logic [4:0] c);
    logic [4:0] d;
    d = c - ALUCTRL_MUL;
    return d[2:0];
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: synchronous FIFO of encoded words.
//  clk, rst_n (sync, active-low) | push, push_data | pop | head (entry at read
//  pointer), nxt_word (word one behind head, lets the writer stream back-to-back)
//  | full, empty, count. Push while full and pop while empty are ignored.
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fifo_entry_t        push_data,
  input  logic               pop,
  output fifo_entry_t        head,
  output logic [INSTR_W-1:0] nxt_word,
  output logic               full,
  output logic               empty,
  output logic [PTR_W:0]     count
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             do_push, do_pop;

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign nxt_word   = mem[rd_ptr_nxt].word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // storage needs no reset: pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: encodes decoded micro-ops into RV32I/M words, buffers
// them and streams them into an instruction-memory write port.
//  clk, rst_n (sync, active-low)
//  in_valid/in_ready, in_class, in_aluctrl, in_rd/rs1/rs2, in_imm, in_last : micro-op in
//  mem_wen, mem_addr, mem_wdata, mem_stall : IMEM write port (request held while stalled)
//  err_illegal (1-cycle pulse), err_count (saturating), busy, done
// Build option: define INSTR_ENC_RVM_EN to accept MUL..REMU in class R;
// otherwise those codes are rejected as illegal.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_aluctrl,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [BITS-1:0]   in_imm,
  input  logic              in_last,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BITS-1:0]   mem_wdata,
  input  logic              mem_stall,
  output logic              err_illegal,
  output logic [7:0]        err_count,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  enc_state_e         state;
  op_dec_t            ad, bd;
  logic [INSTR_W-1:0] enc_word;
  logic               enc_illegal;
  logic               accept, push, pop, more;
  logic               last_drop;   // an illegal in_last was seen; finish once drained
  fifo_entry_t        push_entry, fifo_head;
  logic [INSTR_W-1:0] fifo_nxt_word, next_word;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_imm;

  assign unused_imm = ^in_imm[BITS-1:21];

  // ---------------- encoder ----------------
  always_comb begin
    ad          = alu_decode(in_aluctrl);
    bd          = branch_decode(in_aluctrl);
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (in_class)
      ENC_CLASS_R: begin
        if (ad.ok)
          enc_word = {ad.alt ? F7_ALT : F7_BASE, in_rs2, in_rs1, ad.f3, in_rd, OPC_OP};
`ifdef INSTR_ENC_RVM_EN
        else if (is_muldiv(in_aluctrl))
          enc_word = {F7_MULDIV, in_rs2, in_rs1, muldiv_f3(in_aluctrl), in_rd, OPC_OP};
`endif
        else
          enc_illegal = 1'b1;
      end
      ENC_CLASS_I_CALC: begin
        if (!ad.ok || in_aluctrl == ALUCTRL_SUB)
          enc_illegal = 1'b1;
        else if (ad.f3 == F3_SLL || ad.f3 == F3_SR)
          enc_word = {1'b0, ad.alt, 5'b0, in_imm[4:0], in_rs1, ad.f3, in_rd, OPC_OP_IMM};
        else
          enc_word = {in_imm[11:0], in_rs1, ad.f3, in_rd, OPC_OP_IMM};
      end
      ENC_CLASS_LOAD: begin
        if (in_aluctrl != ALUCTRL_ADD) enc_illegal = 1'b1;
        else enc_word = {in_imm[11:0], in_rs1, F3_WORD, in_rd, OPC_LOAD};
      end
      ENC_CLASS_STORE: begin
        if (in_aluctrl != ALUCTRL_ADD) enc_illegal = 1'b1;
        else enc_word = {in_imm[11:5], in_rs2, in_rs1, F3_WORD, in_imm[4:0], OPC_STORE};
      end
      ENC_CLASS_BRANCH: begin
        if (!bd.ok || in_imm[0]) enc_illegal = 1'b1;
        else enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, bd.f3,
                         in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      ENC_CLASS_JAL: begin
        if (in_aluctrl != ALUCTRL_JAL || in_imm[0]) enc_illegal = 1'b1;
        else enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      ENC_CLASS_JALR: begin
        if (in_aluctrl != ALUCTRL_JALR) enc_illegal = 1'b1;
        else enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      ENC_CLASS_AUIPC: begin
        // in_imm carries the 20-bit upper-immediate value itself
        if (in_aluctrl != ALUCTRL_AUIPC) enc_illegal = 1'b1;
        else enc_word = {in_imm[19:0], in_rd, OPC_AUIPC};
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  // ---------------- buffer ----------------
  assign in_ready   = !fifo_full && (state != ST_DONE);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !enc_illegal;
  assign push_entry = '{last: in_last, word: enc_word};

  // a held request completes on any edge where it is not stalled
  assign pop  = (state == ST_WRITE || state == ST_STALL) && !mem_stall;
  // something left after this pop; with a single entry the follower is the word being pushed
  assign more      = (fifo_count > CNT_W'(1)) || push;
  assign next_word = (fifo_count > CNT_W'(1)) ? fifo_nxt_word : enc_word;

  instr_enc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .nxt_word  (fifo_nxt_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy = !fifo_empty || mem_wen;
  assign done = (state == ST_DONE);

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mem_wen     <= 1'b0;
      mem_addr    <= ADDR_W'(BASE_ADDR);
      mem_wdata   <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
      last_drop   <= 1'b0;
    end else begin
      err_illegal <= accept && enc_illegal;
      if (accept && enc_illegal) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (in_last) last_drop <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_wen   <= 1'b1;
            mem_wdata <= BITS'(fifo_head.word);
            state     <= ST_WRITE;
          end else if (last_drop) begin
            state <= ST_DONE;
          end
        end
        ST_WRITE, ST_STALL: begin
          if (mem_stall) begin
            state <= ST_STALL;   // outputs hold
          end else begin
            mem_addr <= mem_addr + ADDR_W'(4);   // wraps modulo 2^ADDR_W
            if (fifo_head.last) begin
              mem_wen <= 1'b0;
              state   <= ST_DONE;
            end else if (more) begin
              mem_wdata <= BITS'(next_word);
              state     <= ST_WRITE;
            end else begin
              mem_wen <= 1'b0;
              state   <= ST_IDLE;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, mem_stall = 1'b0;
  logic [2:0]  in_class = '0;
  logic [4:0]  in_aluctrl = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;

  logic        d_in_ready, d_mem_wen, d_err_illegal, d_busy, d_done;
  logic [11:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [7:0]  d_err_count;
  logic        w_in_ready, w_mem_wen, w_err_illegal, w_busy, w_done;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [7:0]  w_err_count;

  always #5 clk = ~clk;

  instr_stream_encoder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_class(in_class), .in_aluctrl(in_aluctrl), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .mem_wen(d_mem_wen),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_stall(mem_stall),
    .err_illegal(d_err_illegal), .err_count(d_err_count), .busy(d_busy), .done(d_done));

  instr_stream_encoder #(.ADDR_W(4), .BASE_ADDR(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_class(in_class), .in_aluctrl(in_aluctrl), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .mem_wen(w_mem_wen),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_stall(mem_stall),
    .err_illegal(w_err_illegal), .err_count(w_err_count), .busy(w_busy), .done(w_done));

  // write monitors: a request visible mid-cycle with no stall is taken at the next edge
  logic [11:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  qw_addr[$];
  always @(negedge clk) begin
    if (rst_n && d_mem_wen && !mem_stall) begin
      q_addr.push_back(d_mem_addr);
      q_data.push_back(d_mem_wdata);
    end
    if (rst_n && w_mem_wen && !mem_stall) qw_addr.push_back(w_mem_addr);
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    qw_addr.delete();
  endtask

  // present one micro-op, wait (bounded) for in_ready, return err_illegal after accept
  task automatic send(input logic [2:0] c, input logic [4:0] a, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic last, output logic ill);
    int n = 0;
    in_valid = 1'b1; in_class = c; in_aluctrl = a; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    while (!d_in_ready && n < 100) begin step(); n++; end
    if (!d_in_ready) chk("send_timeout", 32'(d_in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    ill = d_err_illegal;
  endtask

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  code, rd, rs1, rs2;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] word;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c, input logic [4:0] a, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic ill, input logic [31:0] w);
    vec_t v;
    v.cls = c; v.code = a; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.ill = ill; v.word = w;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t tbl[NV];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ill;
    logic [11:0] exp_addr;
    int          n_ill;

    tbl[0]  = mk(ENC_CLASS_R,      ALUCTRL_ADD,   5'd3, 5'd1, 5'd2, 32'd0,       1'b0, 32'h002081B3);
    tbl[1]  = mk(ENC_CLASS_I_CALC, ALUCTRL_ADD,   5'd1, 5'd0, 5'd0, 32'd5,       1'b0, 32'h00500093);
    tbl[2]  = mk(ENC_CLASS_R,      ALUCTRL_SUB,   5'd5, 5'd6, 5'd7, 32'd0,       1'b0, 32'h407302B3);
    tbl[3]  = mk(ENC_CLASS_BRANCH, ALUCTRL_BEQ,   5'd0, 5'd1, 5'd2, 32'd8,       1'b0, 32'h00208463);
    tbl[4]  = mk(ENC_CLASS_BRANCH, ALUCTRL_BEQ,   5'd0, 5'd1, 5'd2, 32'd7,       1'b1, 32'h0);
`ifdef INSTR_ENC_RVM_EN
    tbl[5]  = mk(ENC_CLASS_R,      ALUCTRL_MUL,   5'd1, 5'd2, 5'd3, 32'd0,       1'b0, 32'h023100B3);
`else
    tbl[5]  = mk(ENC_CLASS_R,      ALUCTRL_MUL,   5'd1, 5'd2, 5'd3, 32'd0,       1'b1, 32'h0);
`endif
    tbl[6]  = mk(ENC_CLASS_I_CALC, ALUCTRL_SRA,   5'd4, 5'd5, 5'd0, 32'd3,       1'b0, 32'h4032D213);
    tbl[7]  = mk(ENC_CLASS_LOAD,   ALUCTRL_ADD,   5'd6, 5'd2, 5'd0, 32'd16,      1'b0, 32'h01012303);
    tbl[8]  = mk(ENC_CLASS_STORE,  ALUCTRL_ADD,   5'd0, 5'd2, 5'd5, 32'd8,       1'b0, 32'h00512423);
    tbl[9]  = mk(ENC_CLASS_JAL,    ALUCTRL_JAL,   5'd1, 5'd0, 5'd0, 32'd16,      1'b0, 32'h010000EF);
    tbl[10] = mk(ENC_CLASS_JALR,   ALUCTRL_JALR,  5'd0, 5'd1, 5'd0, 32'd0,       1'b0, 32'h00008067);
    tbl[11] = mk(ENC_CLASS_AUIPC,  ALUCTRL_AUIPC, 5'd5, 5'd0, 5'd0, 32'h12345,   1'b0, 32'h12345297);
    tbl[12] = mk(ENC_CLASS_I_CALC, ALUCTRL_SUB,   5'd1, 5'd2, 5'd0, 32'd1,       1'b1, 32'h0);
    tbl[13] = mk(ENC_CLASS_R,      ALUCTRL_NOP,   5'd1, 5'd2, 5'd3, 32'd0,       1'b1, 32'h0);
    tbl[14] = mk(ENC_CLASS_LOAD,   ALUCTRL_SUB,   5'd1, 5'd2, 5'd0, 32'd4,       1'b1, 32'h0);
    tbl[15] = mk(ENC_CLASS_BRANCH, ALUCTRL_BNE,   5'd0, 5'd3, 5'd4, 32'hFFFFFFFC, 1'b0, 32'hFE419EE3);
    tbl[16] = mk(ENC_CLASS_JAL,    ALUCTRL_JAL,   5'd1, 5'd0, 5'd0, 32'd9,       1'b1, 32'h0);
    tbl[17] = mk(ENC_CLASS_R,      ALUCTRL_SLT,   5'd1, 5'd2, 5'd3, 32'd0,       1'b0, 32'h003120B3);
    tbl[18] = mk(ENC_CLASS_I_CALC, ALUCTRL_AND,   5'd7, 5'd8, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF47393);

    // ---- reset state ----
    do_reset();
    chk("rst_mem_wen",   32'(d_mem_wen), 32'd0);
    chk("rst_mem_addr",  32'(d_mem_addr), 32'd0);
    chk("rst_mem_wdata", d_mem_wdata, 32'd0);
    chk("rst_err_ill",   32'(d_err_illegal), 32'd0);
    chk("rst_err_count", 32'(d_err_count), 32'd0);
    chk("rst_busy",      32'(d_busy), 32'd0);
    chk("rst_done",      32'(d_done), 32'd0);
    chk("rst_in_ready",  32'(d_in_ready), 32'd1);
    chk("rst_wrap_addr", 32'(w_mem_addr), 32'd8);

    // ---- encoding table, one op at a time ----
    exp_addr = '0;
    n_ill = 0;
    for (int i = 0; i < NV; i++) begin
      clear_q();
      send(tbl[i].cls, tbl[i].code, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b0, ill);
      chk($sformatf("v%0d_err_illegal", i), 32'(ill), 32'(tbl[i].ill));
      repeat (4) step();
      chk($sformatf("v%0d_nwrites", i), 32'(q_data.size()), tbl[i].ill ? 32'd0 : 32'd1);
      if (tbl[i].ill) n_ill++;
      else if (q_data.size() == 1) begin
        chk($sformatf("v%0d_word", i), q_data[0], tbl[i].word);
        chk($sformatf("v%0d_addr", i), 32'(q_addr[0]), 32'(exp_addr));
        exp_addr = exp_addr + 12'd4;
      end
    end
    chk("tbl_err_count", 32'(d_err_count), 32'(n_ill));
    chk("tbl_busy_idle", 32'(d_busy), 32'd0);

    // ---- err_count saturation ----
    for (int i = 0; i < 260; i++)
      send(ENC_CLASS_R, ALUCTRL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ill);
    step();
    chk("sat_err_count", 32'(d_err_count), 32'd255);

    // ---- stall with full FIFO ----
    do_reset();
    clear_q();
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      send(tbl[i].cls, tbl[i].code, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b0, ill);
    chk("stall_in_ready", 32'(d_in_ready), 32'd0);
    chk("stall_busy", 32'(d_busy), 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_wen", c),   32'(d_mem_wen), 32'd1);
      chk($sformatf("stall%0d_addr", c),  32'(d_mem_addr), 32'd0);
      chk($sformatf("stall%0d_wdata", c), d_mem_wdata, tbl[0].word);
      step();
    end
    mem_stall = 1'b0;
    repeat (10) step();
    chk("drain_nwrites", 32'(q_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_data.size()) begin
        chk($sformatf("drain%0d_word", i), q_data[i], tbl[i].word);
        chk($sformatf("drain%0d_addr", i), 32'(q_addr[i]), 32'(i * 4));
      end
    end

    // ---- address wrap, last op, done ----
    do_reset();
    clear_q();
    for (int i = 0; i < 4; i++)
      send(tbl[i].cls, tbl[i].code, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, i == 3, ill);
    repeat (6) step();
    chk("wrap_nwrites", 32'(qw_addr.size()), 32'd4);
    if (qw_addr.size() == 4) begin
      chk("wrap_addr0", 32'(qw_addr[0]), 32'd8);
      chk("wrap_addr1", 32'(qw_addr[1]), 32'd12);
      chk("wrap_addr2", 32'(qw_addr[2]), 32'd0);
      chk("wrap_addr3", 32'(qw_addr[3]), 32'd4);
    end
    chk("wrap_done",     32'(w_done), 32'd1);
    chk("wrap_in_ready", 32'(w_in_ready), 32'd0);
    chk("wrap_mem_wen",  32'(w_mem_wen), 32'd0);
    chk("wrap_busy",     32'(w_busy), 32'd0);
    chk("dut_done",      32'(d_done), 32'd1);

    // ---- illegal last op still finishes the program ----
    do_reset();
    clear_q();
    send(ENC_CLASS_BRANCH, ALUCTRL_BEQ, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1, ill);
    chk("illast_pulse", 32'(ill), 32'd1);
    repeat (4) step();
    chk("illast_done",     32'(d_done), 32'd1);
    chk("illast_in_ready", 32'(d_in_ready), 32'd0);
    chk("illast_nwrites",  32'(q_data.size()), 32'd0);

    // ---- reset while stalled ----
    do_reset();
    clear_q();
    mem_stall = 1'b1;
    send(ENC_CLASS_R, ALUCTRL_NOP, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, ill);
    send(tbl[0].cls, tbl[0].code, tbl[0].rd, tbl[0].rs1, tbl[0].rs2, tbl[0].imm, 1'b0, ill);
    repeat (3) step();
    chk("pre_rst_wen",   32'(d_mem_wen), 32'd1);
    chk("pre_rst_count", 32'(d_err_count), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_wen",      32'(d_mem_wen), 32'd0);
    chk("mrst_addr",     32'(d_mem_addr), 32'd0);
    chk("mrst_wdata",    d_mem_wdata, 32'd0);
    chk("mrst_err_ill",  32'(d_err_illegal), 32'd0);
    chk("mrst_count",    32'(d_err_count), 32'd0);
    chk("mrst_busy",     32'(d_busy), 32'd0);
    chk("mrst_done",     32'(d_done), 32'd0);
    chk("mrst_in_ready", 32'(d_in_ready), 32'd1);
    mem_stall = 1'b0;
    repeat (5) step();
    chk("mrst_nwrites",  32'(q_data.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
